// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch front end. Holds the fetch PC, reads one word-aligned
//   instruction per cycle from a combinational ROM while prefetch queue space
//   exists, buffers {pc, inst, excp} entries and presents the queue head to
//   decode over a valid/ready handshake. A redirect flushes the queue and
//   restarts fetch at the new target. A misaligned fetch PC produces a single
//   exception marker entry and parks fetch in HALT until redirect or reset.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        prefetch queue entries (power of two, 1..8)
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   rom_ce       ROM chip enable (1 = read), combinational
//   rom_addr     ROM byte address, word-aligned whenever rom_ce = 1
//   rom_inst     ROM read data, valid in the same cycle as rom_addr
//   redirect     flush queue and restart fetch at redirect_pc
//   redirect_pc  new fetch address
//   out_valid    queue head presented to decode
//   out_ready    decode accepts the head this cycle
//   out_pc       PC of head entry
//   out_inst     instruction of head entry (0 for exception markers)
//   out_excp     head entry is a misaligned-fetch marker
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_excp
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Fetch control state
  logic [0:0]       state_q,    state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;

  // Prefetch queue storage (contents only meaningful below count_q)
  logic [31:0] ent_pc_q   [DEPTH];
  logic [31:0] ent_inst_q [DEPTH];
  logic        ent_excp_q [DEPTH];

  // Per-cycle handshake / push controls
  logic        pop;
  logic        space;
  logic        push;
  logic [31:0] push_inst;
  logic        push_excp;

  // Circular pointer increment; explicit wrap keeps DEPTH=1 correct
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Head presentation; out_valid never depends on out_ready
  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0;
    out_inst  = 32'h0;
    out_excp  = 1'b0;
    if (!rst) begin
      out_valid = (count_q != '0) && !redirect;
      out_pc    = ent_pc_q[rd_ptr_q];
      out_inst  = ent_inst_q[rd_ptr_q];
      out_excp  = ent_excp_q[rd_ptr_q];
    end
  end

  assign pop   = out_valid & out_ready;
  // A slot freed by this cycle's pop can be refilled in the same cycle
  assign space = (count_q < CNT_W'(DEPTH)) | pop;

  assign rom_addr = rst ? 32'h0 : fetch_pc_q;

  // Next-state, ROM enable and push decisions
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rom_ce     = 1'b0;
    push       = 1'b0;
    push_inst  = 32'h0;
    push_excp  = 1'b0;

    if (rst) begin
      // register block applies the reset values
    end else if (redirect) begin
      // Flush wins over full, HALT and a simultaneous out_ready
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (space) begin
            push = 1'b1;
            if (fetch_pc_q[1:0] == 2'b00) begin
              rom_ce     = 1'b1;
              push_inst  = rom_inst;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
              // Misaligned target: emit one marker, then stop fetching
              push_excp = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
        default: begin
          // HALT: no fetches, queue keeps draining
        end
      endcase

      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; cleared logically by count/pointers, so no data reset
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_q[wr_ptr_q]   <= fetch_pc_q;
      ent_inst_q[wr_ptr_q] <= push_inst;
      ent_excp_q[wr_ptr_q] <= push_excp;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Self-checking bench for inst_fetch. A queue-based reference model of the
//   fetch front end predicts every output each cycle; directed scenarios add
//   explicit checks on the sequence of accepted instructions, followed by a
//   randomized phase of ready/redirect/reset traffic.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;

  inst_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce      (rom_ce),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_excp    (out_excp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: word n holds 32'h1000_0000 + n
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom_word(rom_addr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of fetched entries plus fetch PC/halt flag
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc   = RESET_PC;
  logic        m_halt = 1'b0;
  logic        m_pop;
  logic        m_space;

  // Log of entries decode actually accepted from the DUT
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  logic        acc_excp[$];

  task automatic model_check();
    logic exp_valid;
    logic exp_ce;
    if (rst) begin
      check("rst_rom_ce",    32'(rom_ce),    32'h0);
      check("rst_rom_addr",  rom_addr,       32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_pc",    out_pc,         32'h0);
      check("rst_out_inst",  out_inst,       32'h0);
      check("rst_out_excp",  32'(out_excp),  32'h0);
      m_pop   = 1'b0;
      m_space = 1'b0;
    end else begin
      exp_valid = !redirect && (mq.size() > 0);
      m_pop     = exp_valid && out_ready;
      m_space   = (mq.size() < int'(DEPTH)) || m_pop;
      exp_ce    = !redirect && !m_halt && m_space && (m_pc[1:0] == 2'b00);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("rom_ce",    32'(rom_ce),    32'(exp_ce));
      if (exp_ce) begin
        check("rom_addr", rom_addr, m_pc);
      end
      if (exp_valid) begin
        check("out_pc",   out_pc,        mq[0].pc);
        check("out_inst", out_inst,      mq[0].inst);
        check("out_excp", 32'(out_excp), 32'(mq[0].excp));
      end
    end
  endtask

  task automatic model_update();
    ent_t e;
    if (rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (redirect) begin
      mq.delete();
      m_pc   = redirect_pc;
      m_halt = 1'b0;
    end else begin
      if (m_pop) begin
        void'(mq.pop_front());
      end
      if (!m_halt && m_space) begin
        e.pc = m_pc;
        if (m_pc[1:0] == 2'b00) begin
          e.inst = rom_word(m_pc);
          e.excp = 1'b0;
          m_pc   = m_pc + 32'd4;
        end else begin
          e.inst = 32'h0;
          e.excp = 1'b1;
          m_halt = 1'b1;
        end
        mq.push_back(e);
      end
    end
  endtask

  // One clock cycle: drive, settle, check, clock, advance model
  task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #2;
    model_check();
    if (out_valid && out_ready) begin
      acc_pc.push_back(out_pc);
      acc_inst.push_back(out_inst);
      acc_excp.push_back(out_excp);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_log();
    acc_pc.delete();
    acc_inst.delete();
    acc_excp.delete();
  endtask

  function automatic logic [31:0] log_pc(input int i);
    return (acc_pc.size() > i) ? acc_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] log_inst(input int i);
    return (acc_inst.size() > i) ? acc_inst[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] rpc;
    logic        r;
    logic        rd;
    logic        rdy;

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, then streaming with out_ready high
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
    clear_log();
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("stream_count", 32'(acc_pc.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check("stream_pc",   log_pc(i),   32'(i * 4));
      check("stream_inst", log_inst(i), 32'h1000_0000 + 32'(i));
    end

    // Back-pressure after reset: two entries held, then drained in order
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    clear_log();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("bp_pc0", log_pc(0), 32'h0);
    check("bp_pc1", log_pc(1), 32'h4);
    check("bp_pc2", log_pc(2), 32'h8);

    // Redirect with queued entries and out_ready high
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    clear_log();
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("redir_pc0", log_pc(0), 32'h100);
    check("redir_pc1", log_pc(1), 32'h104);

    // Misaligned redirect: one marker, then silence until a new redirect
    clear_log();
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_count", 32'(acc_pc.size()), 32'd1);
    check("mis_pc",    log_pc(0),          32'h102);
    check("mis_inst",  log_inst(0),        32'h0);
    check("mis_excp",  32'(acc_excp.size() > 0 ? acc_excp[0] : 1'b0), 32'h1);
    clear_log();
    cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("resume_pc", log_pc(0), 32'h200);

    // Address wrap
    clear_log();
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_pc0", log_pc(0), 32'hFFFF_FFF8);
    check("wrap_pc1", log_pc(1), 32'hFFFF_FFFC);
    check("wrap_pc2", log_pc(2), 32'h0000_0000);

    // Reset mid-stream with a full queue
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    clear_log();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_mid_pc0", log_pc(0), RESET_PC);
    check("rst_mid_pc1", log_pc(1), RESET_PC + 32'd4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rpc = rpc | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      cycle(r, rd, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch front end that drives the instruction ROM's `ce`/`addr` port and returns fetched words to decode. Holds the fetch PC, issues one word-aligned read per cycle while buffer space exists, captures the combinational ROM read data into a small prefetch queue, and presents entries to the IF/ID stage through a valid/ready handshake. A redirect input (branch/jump/exception target) flushes the queue and restarts fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, prefetch queue entries (power of two, 1..8)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `rom_ce`  out  1  ROM chip enable, 1 = read
- `rom_addr`  out  32  ROM byte address, always word-aligned when `rom_ce`=1
- `rom_inst`  in  32  ROM read data, valid combinationally in the same cycle as `rom_addr`
- `redirect`  in  1  flush queue and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new fetch address
- `out_valid`  out  1  queue head presented
- `out_ready`  in  1  decode accepts head this cycle
- `out_pc`  out  32  PC of head entry
- `out_inst`  out  32  instruction of head entry (32'h0 when `out_excp`=1)
- `out_excp`  out  1  head entry is a misaligned-fetch marker

## Operation
- State: `fetch_pc` (32b), queue of `DEPTH` entries {pc, inst, excp}, read/write pointers, `count` (0..DEPTH), FSM {RUN, HALT}.
- Reset (`rst`=1 at an edge): `fetch_pc`←RESET_PC, `count`←0, pointers←0, FSM←RUN. During any cycle with `rst`=1: `rom_ce`=0, `rom_addr`=0, `out_valid`=0, `out_pc`=0, `out_inst`=0, `out_excp`=0. Reset mid-operation discards all entries; no partial state survives.
- `pop` = `out_valid` & `out_ready`.
- `space` = (`count` < DEPTH) | `pop`.
- RUN, `fetch_pc[1:0]`=0, `space`, no `redirect`: `rom_ce`=1, `rom_addr`=`fetch_pc`; at the edge push {fetch_pc, rom_inst, 0} and `fetch_pc`←`fetch_pc`+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
- RUN, `fetch_pc[1:0]`≠0, `space`, no `redirect`: `rom_ce`=0; push {fetch_pc, 0, 1}; FSM→HALT; `fetch_pc` unchanged.
- HALT: `rom_ce`=0, no pushes; queue drains normally; leaves only on `redirect` or `rst`.
- No `space`: `rom_ce`=0, `fetch_pc` held.
- `rom_ce`=0 ⇒ `rom_addr`=`fetch_pc` with low bits as held (value don't-care to ROM; bench checks `rom_ce` only).
- `redirect`=1 (and `rst`=0): `rom_ce`=0 and `out_valid`=0 that cycle; no push, no pop. At the edge `count`←0, pointers←0, `fetch_pc`←`redirect_pc`, FSM←RUN. Redirect overrides full, HALT and a simultaneous `out_ready`.
- Push and pop in the same cycle with `count`=DEPTH: both occur, `count` unchanged. Sustained throughput 1 instr/cycle while `out_ready`=1.
- `out_*` are driven from the head entry; they are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Cycle 0 = first cycle with `rst`=0: `rom_ce`=1, `rom_addr`=RESET_PC.
- Cycle 1: `out_valid`=1, `out_pc`=RESET_PC. Fetch-to-present latency = 1 cycle.
- Redirect asserted in cycle k: cycle k+1 `rom_addr`=`redirect_pc`; cycle k+2 `out_valid`=1 with `out_pc`=`redirect_pc`.
- `out_ready` low for N cycles with queue full: exactly DEPTH entries held, `rom_ce`=0 throughout; the first cycle `out_ready` returns high, a pop and a push occur together.
- No combinational path from `out_ready` to `out_valid`; `rom_ce` depends combinationally on `out_ready`, `redirect`, `rst`.

## Test plan
- Reset release, ROM word n = 32'h1000_0000+n, `out_ready`=1 → `out_pc` 0,4,8,… on consecutive cycles starting cycle 1, `out_inst` 32'h1000_0000, 32'h1000_0001, …, no bubbles.
- `out_ready`=0 for 5 cycles after reset → exactly 2 entries (pc 0, 4) buffered, `rom_ce`=0 from cycle 2; raise `out_ready` → pc 0,4,8 in order, no loss or duplication.
- `redirect`=1, `redirect_pc`=32'h0000_0100 with 2 entries queued and `out_ready`=1 → `out_valid`=0 that cycle, next presented `out_pc`=32'h100 two cycles later, stale pc never appears.
- Redirect to 32'h0000_0102 → one entry `out_pc`=32'h102, `out_excp`=1, `out_inst`=0, then `rom_ce`=0 and `out_valid`=0 until redirect to 32'h200 resumes normally.
- Redirect to 32'hFFFF_FFF8 → `out_pc` FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` for one cycle mid-stream with full queue → all outputs 0 that cycle, next cycle `rom_addr`=RESET_PC, old entries never presented.
